microcoded_state_machine: RTL and testbench

- Small control FSM whose next state and Moore outputs come entirely from an 8-entry microcode ROM indexed by a 3-bit state register.
- Four condition inputs A–D steer branches; three control outputs X, Y, Z are decoded from the current microword.
- Serves as a reusable sequencer template: behaviour changes by editing ROM contents only, not logic.

---
 rtl/microcoded_state_machine_pkg.sv | 58 +++++
 rtl/msm_ucode_rom.sv | 29 ++
 rtl/microcoded_state_machine.sv | 48 ++++
 tb/tb_microcoded_state_machine.sv | 129 ++++++++++++
 4 files changed

// File: rtl/microcoded_state_machine_pkg.sv
// Shared types and constants for the microcoded sequencer: state codes, condition selects,
// microword layout. Optional trap variant of S7 is selected by MSM_ILLEGAL_TRAP_EN.
package microcoded_state_machine_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned ROM_DEPTH = 1 << STATE_W;

    localparam int unsigned OUT_W   = 3;
    localparam int unsigned CSEL_W  = 3;
    localparam int unsigned UWORD_W = OUT_W + CSEL_W + 2 * STATE_W;

    localparam int unsigned NF_LSB   = 0;
    localparam int unsigned NT_LSB   = NF_LSB + STATE_W;
    localparam int unsigned CSEL_LSB = NT_LSB + STATE_W;
    localparam int unsigned OUT_LSB  = CSEL_LSB + CSEL_W;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    localparam logic [STATE_W-1:0] RESET_STATE = S0;

    // Codes 5..7 are reserved and behave like CSEL_ALWAYS.
    localparam logic [CSEL_W-1:0] CSEL_ALWAYS = 3'd0;
    localparam logic [CSEL_W-1:0] CSEL_A      = 3'd1;
    localparam logic [CSEL_W-1:0] CSEL_B      = 3'd2;
    localparam logic [CSEL_W-1:0] CSEL_C      = 3'd3;
    localparam logic [CSEL_W-1:0] CSEL_D      = 3'd4;

    typedef struct packed {
        logic [OUT_W-1:0]   xyz;
        logic [CSEL_W-1:0]  csel;
        logic [STATE_W-1:0] nt;
        logic [STATE_W-1:0] nf;
    } uword_t;

    // Packs one ROM entry using the declared field positions.
    function automatic uword_t mk_uword(input logic [OUT_W-1:0]   xyz,
                                       input logic [CSEL_W-1:0]  csel,
                                       input logic [STATE_W-1:0] nt,
                                       input logic [STATE_W-1:0] nf);
        logic [UWORD_W-1:0] w;
        w = '0;
        w[OUT_LSB  +: OUT_W]   = xyz;
        w[CSEL_LSB +: CSEL_W]  = csel;
        w[NT_LSB   +: STATE_W] = nt;
        w[NF_LSB   +: STATE_W] = nf;
        return uword_t'(w);
    endfunction

endpackage

// File: rtl/msm_ucode_rom.sv
// Combinational 8x12 microcode ROM: current state -> microword.
// MSM_ILLEGAL_TRAP_EN turns S7 into a self-holding trap with XYZ = 111.
module msm_ucode_rom
    import microcoded_state_machine_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    output uword_t             uword_c
);

    always_comb begin
        uword_c = mk_uword(3'b000, CSEL_ALWAYS, S0, S0);
        case (state)
            S0: uword_c = mk_uword(3'b000, CSEL_A,      S0, S1);
            S1: uword_c = mk_uword(3'b100, CSEL_B,      S2, S4);
            S2: uword_c = mk_uword(3'b010, CSEL_C,      S0, S3);
            S3: uword_c = mk_uword(3'b011, CSEL_ALWAYS, S0, S0);
            S4: uword_c = mk_uword(3'b001, CSEL_ALWAYS, S5, S5);
            S5: uword_c = mk_uword(3'b101, CSEL_D,      S6, S4);
            S6: uword_c = mk_uword(3'b110, CSEL_ALWAYS, S0, S0);
`ifdef MSM_ILLEGAL_TRAP_EN
            S7: uword_c = mk_uword(3'b111, CSEL_ALWAYS, S7, S7);
`else
            S7: uword_c = mk_uword(3'b000, CSEL_ALWAYS, S0, S0);
`endif
            default: uword_c = mk_uword(3'b000, CSEL_ALWAYS, S0, S0);
        endcase
    end

endmodule

// File: rtl/microcoded_state_machine.sv
// ROM-driven Moore sequencer: State register plus condition mux; XYZ decoded from ROM[State].
// Build with MSM_ILLEGAL_TRAP_EN to make unused state S7 a trap.
module microcoded_state_machine
    import microcoded_state_machine_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic X,
    output logic Y,
    output logic Z
);

    logic [STATE_W-1:0] State;
    uword_t             uword_c;
    logic               cond_c;

    msm_ucode_rom u_rom (
        .state   (State),
        .uword_c (uword_c)
    );

    // if-style tests so an unknown condition input falls to the false branch
    always_comb begin
        cond_c = 1'b0;
        case (uword_c.csel)
            CSEL_A:  if (A) cond_c = 1'b1;
            CSEL_B:  if (B) cond_c = 1'b1;
            CSEL_C:  if (C) cond_c = 1'b1;
            CSEL_D:  if (D) cond_c = 1'b1;
            default: cond_c = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            State <= RESET_STATE;
        end else begin
            State <= cond_c ? uword_c.nt : uword_c.nf;
        end
    end

    assign {X, Y, Z} = uword_c.xyz;

endmodule

// File: tb/tb_microcoded_state_machine.sv
// Directed bench for microcoded_state_machine; S7 expectations follow MSM_ILLEGAL_TRAP_EN.
module tb_microcoded_state_machine;

    logic Clock;
    logic Reset;
    logic A, B, C, D;
    logic X, Y, Z;

    int checks;
    int failures;

    microcoded_state_machine dut (
        .Clock (Clock),
        .Reset (Reset),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .X     (X),
        .Y     (Y),
        .Z     (Z)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sx(input string tag, input logic [2:0] es, input logic [2:0] ex);
        check({tag, ".state"}, 8'(dut.State), 8'(es));
        check({tag, ".xyz"},   8'({X, Y, Z}), 8'(ex));
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step(input string tag, input logic [2:0] es, input logic [2:0] ex);
        @(posedge Clock);
        @(negedge Clock);
        check_sx(tag, es, ex);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset = 1'b1;
        A = 1'b1; B = 1'b1; C = 1'b0; D = 1'b1;

        @(negedge Clock);
        check_sx("reset", 3'b000, 3'b000);
        step("reset_held", 3'b000, 3'b000);

        Reset = 1'b0;
        for (int i = 0; i < 3; i++) step("a_loop", 3'b000, 3'b000);

        // Left path through S3, twice.
        A = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step("left_s1", 3'b001, 3'b100);
            step("left_s2", 3'b010, 3'b010);
            step("left_s3", 3'b011, 3'b011);
            step("left_s0", 3'b000, 3'b000);
        end

        // C=1 skips S3.
        C = 1'b1;
        step("skip_s1", 3'b001, 3'b100);
        step("skip_s2", 3'b010, 3'b010);
        step("skip_s0", 3'b000, 3'b000);

        // Right path.
        B = 1'b0; D = 1'b1;
        step("right_s1", 3'b001, 3'b100);
        step("right_s4", 3'b100, 3'b001);
        step("right_s5", 3'b101, 3'b101);
        step("right_s6", 3'b110, 3'b110);
        step("right_s0", 3'b000, 3'b000);

        // D=0 keeps alternating S4/S5.
        D = 1'b0;
        step("loop_s1", 3'b001, 3'b100);
        for (int i = 0; i < 3; i++) begin
            step("loop_s4", 3'b100, 3'b001);
            step("loop_s5", 3'b101, 3'b101);
        end

        // Asynchronous reset from S5, observed before any clock edge.
        #1 Reset = 1'b1;
        #1 check_sx("async_rst", 3'b000, 3'b000);
        @(negedge Clock);
        check_sx("rst_hold", 3'b000, 3'b000);

        // First transition only at the edge after release.
        A = 1'b1;
        Reset = 1'b0;
        #2 check_sx("rel_nochg", 3'b000, 3'b000);
        @(negedge Clock);
        A = 1'b0;
        #2 check_sx("rel_inpchg", 3'b000, 3'b000);
        step("rel_first", 3'b001, 3'b100);

        // Illegal state S7.
        B = 1'b0;
        force dut.State = 3'b111;
        #1;
`ifdef MSM_ILLEGAL_TRAP_EN
        check_sx("s7_forced", 3'b111, 3'b111);
        release dut.State;
        step("s7_trap1", 3'b111, 3'b111);
        step("s7_trap2", 3'b111, 3'b111);
        Reset = 1'b1;
        #1 check_sx("s7_reset", 3'b000, 3'b000);
        Reset = 1'b0;
`else
        check_sx("s7_forced", 3'b111, 3'b000);
        release dut.State;
        step("s7_recover", 3'b000, 3'b000);
`endif
        step("post_s7", 3'b001, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
